video_luma_tint_expander: RTL and testbench

Expands an 8-bit luminance pixel stream into tinted 8-bit RGB. This is the inverse path of the RGB-to-mono reduction: it emulates monochrome phosphor colours for mono sources such as MDA/Hercules-style intensity or composite luma.
- Per-channel tint gains and a minimum-glow floor are software-programmable through a small write port.
- Programmed values land in shadow registers and are committed only at the start of vertical blank, so a frame is never tinted with mixed settings.
- Sits between the mono video generator and the scaler/video output, in the clk_vid domain.

---
 rtl/video_luma_tint_expander.sv | 166 ++++++++++++++++
 tb/tb_video_luma_tint_expander.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_luma_tint_expander.sv
// Expands 8-bit luma into tinted RGB: floor clamp, per-channel gain, blank forcing.
// Config writes land in shadow registers and are committed on the vblank rising edge.
module video_luma_tint_expander (
    input  logic       clk_vid,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [7:0] luma,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_pending,
    output logic [7:0] R_OUT,
    output logic [7:0] G_OUT,
    output logic [7:0] B_OUT,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       hblank_out,
    output logic       vblank_out
);

    typedef enum logic [1:0] {
        CFG_GAIN_R = 2'd0,
        CFG_GAIN_G = 2'd1,
        CFG_GAIN_B = 2'd2,
        CFG_FLOOR  = 2'd3
    } cfg_sel_e;

    // out = (l*gain + l) >> 8, so gain 0xFF is exact identity and 0x00 is black
    function automatic logic [15:0] tint(input logic [7:0] l, input logic [7:0] g);
        return ({8'h00, l} * {8'h00, g}) + {8'h00, l};
    endfunction

    cfg_sel_e   cfg_sel;
    logic       commit;

    logic [7:0] sh_r_q, sh_g_q, sh_b_q, sh_f_q;
    logic [7:0] sh_r_d, sh_g_d, sh_b_d, sh_f_d;
    logic [7:0] act_r_q, act_g_q, act_b_q, act_f_q;
    logic [7:0] act_r_d, act_g_d, act_b_d, act_f_d;
    logic       pend_q, pend_d;
    logic       vb_prev_q;
    logic       armed_q;

    // sync/blank bundles are packed {hsync, vsync, hblank, vblank}
    logic [7:0]  l_q, l_d;
    logic [3:0]  s1_sync_q;
    logic [15:0] pr_q, pg_q, pb_q;
    logic [15:0] pr_d, pg_d, pb_d;
    logic [3:0]  s2_sync_q;
    logic [7:0]  r_q, g_q, b_q;
    logic [7:0]  r_d, g_d, b_d;
    logic [3:0]  s3_sync_q;
    logic        s2_blank;

    assign cfg_sel = cfg_sel_e'(cfg_addr);

    // A vblank already high at reset release is not a rising edge: armed_q
    // only sets once vblank_in has been seen low on a pixel cycle.
    assign commit = ce_pix & vblank_in & ~vb_prev_q & armed_q;

    always_comb begin
        sh_r_d  = sh_r_q;
        sh_g_d  = sh_g_q;
        sh_b_d  = sh_b_q;
        sh_f_d  = sh_f_q;
        act_r_d = act_r_q;
        act_g_d = act_g_q;
        act_b_d = act_b_q;
        act_f_d = act_f_q;
        pend_d  = pend_q;

        if (commit) begin
            act_r_d = sh_r_q;
            act_g_d = sh_g_q;
            act_b_d = sh_b_q;
            act_f_d = sh_f_q;
            pend_d  = 1'b0;
        end

        if (cfg_we) begin
            pend_d = 1'b1;
            case (cfg_sel)
                CFG_GAIN_R: sh_r_d = cfg_data;
                CFG_GAIN_G: sh_g_d = cfg_data;
                CFG_GAIN_B: sh_b_d = cfg_data;
                CFG_FLOOR:  sh_f_d = cfg_data;
                default:    sh_f_d = sh_f_q;
            endcase
        end
    end

    always_comb begin
        l_d      = (luma > act_f_q) ? luma : act_f_q;
        pr_d     = tint(l_q, act_r_q);
        pg_d     = tint(l_q, act_g_q);
        pb_d     = tint(l_q, act_b_q);
        s2_blank = s2_sync_q[1] | s2_sync_q[0];
        r_d      = s2_blank ? '0 : pr_q[15:8];
        g_d      = s2_blank ? '0 : pg_q[15:8];
        b_d      = s2_blank ? '0 : pb_q[15:8];
    end

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            sh_r_q    <= '1;
            sh_g_q    <= '1;
            sh_b_q    <= '1;
            sh_f_q    <= '0;
            act_r_q   <= '1;
            act_g_q   <= '1;
            act_b_q   <= '1;
            act_f_q   <= '0;
            pend_q    <= 1'b0;
            vb_prev_q <= 1'b0;
            armed_q   <= 1'b0;
            l_q       <= '0;
            s1_sync_q <= '0;
            pr_q      <= '0;
            pg_q      <= '0;
            pb_q      <= '0;
            s2_sync_q <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            s3_sync_q <= '0;
        end else begin
            sh_r_q  <= sh_r_d;
            sh_g_q  <= sh_g_d;
            sh_b_q  <= sh_b_d;
            sh_f_q  <= sh_f_d;
            act_r_q <= act_r_d;
            act_g_q <= act_g_d;
            act_b_q <= act_b_d;
            act_f_q <= act_f_d;
            pend_q  <= pend_d;
            if (ce_pix) begin
                vb_prev_q <= vblank_in;
                armed_q   <= armed_q | ~vblank_in;
                l_q       <= l_d;
                s1_sync_q <= {hsync_in, vsync_in, hblank_in, vblank_in};
                pr_q      <= pr_d;
                pg_q      <= pg_d;
                pb_q      <= pb_d;
                s2_sync_q <= s1_sync_q;
                r_q       <= r_d;
                g_q       <= g_d;
                b_q       <= b_d;
                s3_sync_q <= s2_sync_q;
            end
        end
    end

    assign cfg_pending = pend_q;
    assign R_OUT       = r_q;
    assign G_OUT       = g_q;
    assign B_OUT       = b_q;
    assign hsync_out   = s3_sync_q[3];
    assign vsync_out   = s3_sync_q[2];
    assign hblank_out  = s3_sync_q[1];
    assign vblank_out  = s3_sync_q[0];

endmodule

// File: tb/tb_video_luma_tint_expander.sv
// Scoreboard bench for video_luma_tint_expander: directed scenarios plus random frames
// checked against a history-based reference model of the tint rules.
module tb_video_luma_tint_expander;

    logic       clk_vid   = 1'b0;
    logic       reset     = 1'b0;
    logic       ce_pix    = 1'b0;
    logic [7:0] luma      = '0;
    logic       hsync_in  = 1'b0;
    logic       vsync_in  = 1'b0;
    logic       hblank_in = 1'b0;
    logic       vblank_in = 1'b0;
    logic       cfg_we    = 1'b0;
    logic [1:0] cfg_addr  = '0;
    logic [7:0] cfg_data  = '0;
    logic       cfg_pending;
    logic [7:0] R_OUT, G_OUT, B_OUT;
    logic       hsync_out, vsync_out, hblank_out, vblank_out;

    int total = 0;
    int bad   = 0;

    video_luma_tint_expander dut (
        .clk_vid    (clk_vid),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .luma       (luma),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_pending(cfg_pending),
        .R_OUT      (R_OUT),
        .G_OUT      (G_OUT),
        .B_OUT      (B_OUT),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblank_out (hblank_out),
        .vblank_out (vblank_out)
    );

    always #5 clk_vid = ~clk_vid;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [3:0] sy;
        logic       pend;
    } exp_t;

    // Reference model: settings, plus per-pixel-cycle history of issued samples
    logic [7:0]  m_sh[4];
    logic [7:0]  m_act[4];
    logic        m_pend;
    logic        m_vprev;
    logic        m_seen_low;
    logic [7:0]  l_hist[$];
    logic [3:0]  s_hist[$];
    logic [23:0] g_hist[$];
    exp_t        m_last;
    exp_t        sb[$];

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] chan(input logic [7:0] l, input logic [7:0] g);
        int unsigned li, gi;
        li = l;
        gi = g;
        return 8'((li * gi + li) / 256);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sh[i]  = 8'hFF;
            m_act[i] = 8'hFF;
        end
        m_sh[3]    = 8'h00;
        m_act[3]   = 8'h00;
        m_pend     = 1'b0;
        m_vprev    = 1'b0;
        m_seen_low = 1'b0;
        l_hist.delete();
        s_hist.delete();
        g_hist.delete();
        m_last = '{8'h00, 8'h00, 8'h00, 4'h0, 1'b0};
    endfunction

    // Output after pixel cycle k: sample issued at k-2 with gains active at k-1
    task automatic tick();
        exp_t e;
        bit   commit;
        int   n;
        logic [7:0]  l;
        logic [23:0] gs;
        commit = ce_pix && vblank_in && !m_vprev && m_seen_low;
        if (ce_pix) begin
            l = (luma > m_act[3]) ? luma : m_act[3];
            l_hist.push_back(l);
            s_hist.push_back({hsync_in, vsync_in, hblank_in, vblank_in});
            g_hist.push_back({m_act[0], m_act[1], m_act[2]});
            n = l_hist.size();
            if (n >= 3) begin
                gs = g_hist[n-2];
                m_last.sy = s_hist[n-3];
                if (s_hist[n-3][1] || s_hist[n-3][0]) begin
                    m_last.r = 8'h00;
                    m_last.g = 8'h00;
                    m_last.b = 8'h00;
                end else begin
                    m_last.r = chan(l_hist[n-3], gs[23:16]);
                    m_last.g = chan(l_hist[n-3], gs[15:8]);
                    m_last.b = chan(l_hist[n-3], gs[7:0]);
                end
            end
            if (!vblank_in) m_seen_low = 1'b1;
            m_vprev = vblank_in;
        end
        if (commit) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end
        if (cfg_we) begin
            m_sh[cfg_addr] = cfg_data;
            m_pend = 1'b1;
        end
        e = m_last;
        e.pend = m_pend;
        @(posedge clk_vid);
        sb.push_back(e);
        #1;
    endtask

    task automatic pix(input logic [7:0] l, input logic [3:0] sy, input logic c);
        luma = l;
        {hsync_in, vsync_in, hblank_in, vblank_in} = sy;
        ce_pix = c;
        tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic vblank_pulse(input int len);
        pix(luma, 4'b0000, 1'b1);
        repeat (len) pix(luma, 4'b0101, 1'b1);
        repeat (3) pix(luma, 4'b0000, 1'b1);
    endtask

    task automatic do_reset(input logic vb_hold);
        vblank_in = vb_hold;
        reset = 1'b1;
        #1;
        chk("rst_R", R_OUT, 8'h00);
        chk("rst_G", G_OUT, 8'h00);
        chk("rst_B", B_OUT, 8'h00);
        chk("rst_sync", {4'h0, hsync_out, vsync_out, hblank_out, vblank_out}, 8'h00);
        chk("rst_pending", {7'h0, cfg_pending}, 8'h00);
        sb.delete();
        model_reset();
        repeat (3) @(posedge clk_vid);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk_vid) begin
        exp_t e;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("R_OUT", R_OUT, e.r);
            chk("G_OUT", G_OUT, e.g);
            chk("B_OUT", B_OUT, e.b);
            chk("sync_blank", {4'h0, hsync_out, vsync_out, hblank_out, vblank_out}, {4'h0, e.sy});
            chk("cfg_pending", {7'h0, cfg_pending}, {7'h0, e.pend});
        end
    end

    initial begin
        model_reset();
        #2;
        do_reset(1'b0);

        // defaults: plain B&W
        repeat (6) pix(8'h80, 4'b0000, 1'b1);

        // green tint written mid-frame stays deferred until vblank rise
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'h00);
        repeat (6) pix(8'hC8, 4'b0000, 1'b1);
        vblank_pulse(4);
        repeat (6) pix(8'hC8, 4'b0000, 1'b1);

        // floor and half gain
        wr(2'd3, 8'h0F);
        wr(2'd1, 8'h80);
        vblank_pulse(3);
        repeat (4) pix(8'h03, 4'b0000, 1'b1);
        repeat (4) pix(8'hFF, 4'b0000, 1'b1);

        // single-pixel hblank and hsync pulses
        pix(8'hFF, 4'b0010, 1'b1);
        repeat (3) pix(8'hFF, 4'b0000, 1'b1);
        pix(8'hFF, 4'b1000, 1'b1);
        repeat (4) pix(8'hFF, 4'b0000, 1'b1);

        // ce_pix gating with changing luma
        for (int i = 0; i < 12; i++) pix(8'(8'h20 + i * 16), 4'b0000, 1'(~i & 1));
        repeat (4) pix(8'h55, 4'b0000, 1'b1);

        // write landing on the commit edge is deferred a whole frame
        cfg_we = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 8'h40;
        pix(8'h90, 4'b0101, 1'b1);
        cfg_we = 1'b0;
        repeat (3) pix(8'h90, 4'b0101, 1'b1);
        repeat (6) pix(8'h90, 4'b0000, 1'b1);
        vblank_pulse(3);
        repeat (6) pix(8'h90, 4'b0000, 1'b1);

        // mid-line reset, vblank held high through release
        pix(8'hA0, 4'b0000, 1'b1);
        do_reset(1'b1);
        wr(2'd0, 8'h00);
        repeat (4) pix(8'hA0, 4'b0101, 1'b1);
        repeat (6) pix(8'hA0, 4'b0000, 1'b1);
        vblank_pulse(3);
        repeat (6) pix(8'hA0, 4'b0000, 1'b1);

        // random frames
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(15) == 0) begin
                    cfg_we = 1'b1;
                    cfg_addr = 2'($urandom_range(3));
                    cfg_data = 8'($urandom);
                end
                pix(8'($urandom), {1'((i % 50) < 4), 1'b0, 1'((i % 50) < 8), 1'b0},
                    1'($urandom_range(3) != 0));
                cfg_we = 1'b0;
            end
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(3) == 0) begin
                    cfg_we = 1'b1;
                    cfg_addr = 2'($urandom_range(3));
                    cfg_data = 8'($urandom);
                end
                pix(8'($urandom), {1'b0, 1'(i < 3), 1'b0, 1'b1}, 1'($urandom_range(3) != 0));
                cfg_we = 1'b0;
            end
        end

        repeat (2) @(posedge clk_vid);
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
